// File: rtl/ipc_port_sequencer.sv
// ipc_port_sequencer: serialises CPU IN/OUT port requests onto the IPCIn/IPCOut device models.
// Define IPC_PORT_STATS_EN to add saturating per-type transaction counters.
module ipc_port_sequencer #(
    parameter int IN_SETTLE_CYCLES = 2,
    parameter int OUT_HOLD_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_out,
    input  logic [7:0]  req_device_id,
    input  logic [31:0] req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [7:0]  ipc_in_device_id,
    input  logic [31:0] ipc_in_value,
    output logic [7:0]  ipc_out_device_id,
    output logic [31:0] ipc_out_value
`ifdef IPC_PORT_STATS_EN
    ,
    output logic [15:0] stat_in_count,
    output logic [15:0] stat_out_count
`endif
);
    localparam int MAX_CYC = (IN_SETTLE_CYCLES > OUT_HOLD_CYCLES) ? IN_SETTLE_CYCLES : OUT_HOLD_CYCLES;
    localparam int CW = $clog2(MAX_CYC + 1);

    if (IN_SETTLE_CYCLES < 1 || OUT_HOLD_CYCLES < 1) begin : g_bad_param
        $error("ipc_port_sequencer: IN_SETTLE_CYCLES and OUT_HOLD_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, IN_WAIT, OUT_HOLD, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic [7:0]    in_id_q, in_id_d;
    logic [7:0]    out_id_q, out_id_d;
    logic [31:0]   out_val_q, out_val_d;

    assign req_ready         = (state_q == IDLE);
    assign rsp_valid         = rsp_valid_q;
    assign rsp_data          = rsp_data_q;
    assign ipc_in_device_id  = in_id_q;
    assign ipc_out_device_id = out_id_q;
    assign ipc_out_value     = out_val_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        in_id_d     = in_id_q;
        out_id_d    = out_id_q;
        out_val_d   = out_val_q;
        case (state_q)
            IDLE: if (req_valid) begin
                if (req_is_out) begin
                    // id and value move on the same edge so IPCOut sees one coherent change
                    out_id_d   = req_device_id;
                    out_val_d  = req_data;
                    rsp_data_d = req_data;
                    cnt_d      = CW'(OUT_HOLD_CYCLES - 1);
                    state_d    = OUT_HOLD;
                end else begin
                    in_id_d = req_device_id;
                    cnt_d   = CW'(IN_SETTLE_CYCLES - 1);
                    state_d = IN_WAIT;
                end
            end
            IN_WAIT, OUT_HOLD: if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = (state_q == IN_WAIT) ? ipc_in_value : rsp_data_q;
                state_d     = RESP;
            end
            RESP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            in_id_q     <= '0;
            out_id_q    <= '0;
            out_val_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            in_id_q     <= in_id_d;
            out_id_q    <= out_id_d;
            out_val_q   <= out_val_d;
        end
    end

`ifdef IPC_PORT_STATS_EN
    logic        is_out_q, is_out_d;
    logic [15:0] stat_in_q, stat_in_d, stat_out_q, stat_out_d;
    logic        done;

    assign done           = (state_q == RESP) && rsp_ready;
    assign stat_in_count  = stat_in_q;
    assign stat_out_count = stat_out_q;

    always_comb begin
        is_out_d   = (state_q == IDLE && req_valid) ? req_is_out : is_out_q;
        stat_in_d  = (done && !is_out_q && stat_in_q != 16'hFFFF) ? stat_in_q + 16'd1 : stat_in_q;
        stat_out_d = (done && is_out_q && stat_out_q != 16'hFFFF) ? stat_out_q + 16'd1 : stat_out_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_out_q   <= 1'b0;
            stat_in_q  <= '0;
            stat_out_q <= '0;
        end else begin
            is_out_q   <= is_out_d;
            stat_in_q  <= stat_in_d;
            stat_out_q <= stat_out_d;
        end
    end
`endif
endmodule
